// File: rtl/vga_sync_generator_if.sv
// Video bus between the colour generator and the VGA timing stage.
// master = timing stage (drives sync, colour and coordinates); slave = colour generator side.
interface vga_sync_generator_if;
    logic [7:0] rgb_in;
    logic [7:0] rgb_out;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       frame_start;

    modport master (
        input  rgb_in,
        output rgb_out, hsync, vsync, video_on, pixel_x, pixel_y, frame_start
    );

    modport slave (
        output rgb_in,
        input  rgb_out, hsync, vsync, video_on, pixel_x, pixel_y, frame_start
    );
endinterface

// File: rtl/vga_sync_generator.sv
// 640x480@60 VGA timing from a 50 MHz clock: half-rate pixel tick, h/v counters,
// registered sync/blank/colour aligned one pixel behind the exported coordinate.
module vga_sync_generator #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic                  CLK_IN,
    input  logic                  RST_N,
    vga_sync_generator_if.master  vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic       r_tick;
    logic [9:0] r_h;
    logic [9:0] r_v;
    logic [7:0] r_rgb;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_video_on;
    logic       r_frame_start;

    logic       w_h_wrap;
    logic       w_v_wrap;
    logic       w_active;
    logic       w_hs_n;
    logic       w_vs_n;
    logic       w_origin;
    logic [9:0] w_h_next;
    logic [9:0] w_v_next;
    logic [7:0] w_rgb_gated;

    assign w_h_wrap = (r_h == H_LAST);
    assign w_v_wrap = (r_v == V_LAST);
    assign w_active = (r_h < H_VIS) && (r_v < V_VIS);
    assign w_hs_n   = !((r_h >= HS_START) && (r_h < HS_END));
    assign w_vs_n   = !((r_v >= VS_START) && (r_v < VS_END));
    assign w_origin = (r_h == 10'd0) && (r_v == 10'd0);

    always_comb begin
        w_h_next = w_h_wrap ? 10'd0 : r_h + 10'd1;
        w_v_next = r_v;
        if (w_h_wrap) begin
            w_v_next = w_v_wrap ? 10'd0 : r_v + 10'd1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_blank
            assign w_rgb_gated[gi] = vga.rgb_in[gi] & w_active;
        end
    endgenerate

    // Pixel-rate state only moves on tick edges; frame_start is the one signal that
    // also updates on the off-tick edge so it stays high for a single CLK_IN cycle.
    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            r_tick        <= 1'b0;
            r_h           <= 10'd0;
            r_v           <= 10'd0;
            r_rgb         <= 8'h00;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_video_on    <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_tick        <= ~r_tick;
            r_frame_start <= r_tick & w_origin;
            if (r_tick) begin
                r_h        <= w_h_next;
                r_v        <= w_v_next;
                r_rgb      <= w_rgb_gated;
                r_hsync    <= w_hs_n;
                r_vsync    <= w_vs_n;
                r_video_on <= w_active;
            end
        end
    end

    assign vga.rgb_out     = r_rgb;
    assign vga.hsync       = r_hsync;
    assign vga.vsync       = r_vsync;
    assign vga.video_on    = r_video_on;
    assign vga.pixel_x     = r_h;
    assign vga.pixel_y     = r_v;
    assign vga.frame_start = r_frame_start;
endmodule

// File: tb/tb_vga_sync_generator.sv
// Bench for vga_sync_generator: a full 640x480 instance for line timing and a
// shrunken-geometry instance so whole frames and a mid-frame reset fit in a short run.
module tb_vga_sync_generator;
    typedef struct packed {
        logic [7:0] rgb;
        logic       hs;
        logic       vs;
        logic       von;
        logic [9:0] x;
        logic [9:0] y;
        logic       fs;
    } obs_t;

    typedef struct {
        logic       rst_n;
        logic [7:0] rgb_full;
        logic [7:0] rgb_small;
        obs_t       exp_full;
        obs_t       exp_small;
    } vec_t;

    localparam int FHA = 640, FHF = 16, FHS = 96, FHB = 48;
    localparam int FVA = 480, FVF = 10, FVS = 2,  FVB = 33;
    localparam int SHA = 16,  SHF = 4,  SHS = 6,  SHB = 6;
    localparam int SVA = 12,  SVF = 2,  SVS = 2,  SVB = 4;
    localparam int F_HT = FHA + FHF + FHS + FHB;
    localparam int F_TOT = F_HT * (FVA + FVF + FVS + FVB);
    localparam int S_HT = SHA + SHF + SHS + SHB;
    localparam int S_TOT = S_HT * (SVA + SVF + SVS + SVB);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vga_sync_generator_if vif_full ();
    vga_sync_generator_if vif_small ();

    vga_sync_generator u_full (
        .CLK_IN (clk),
        .RST_N  (rst_n),
        .vga    (vif_full)
    );

    vga_sync_generator #(
        .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
    ) u_small (
        .CLK_IN (clk),
        .RST_N  (rst_n),
        .vga    (vif_small)
    );

    int   vec_cnt = 0;
    int   miss_cnt = 0;
    obs_t q_full[$];
    obs_t q_small[$];
    obs_t rst_obs;
    int   k;
    int   cyc;
    logic [7:0] trgb_full, trgb_small;

    // line/frame measurements taken from the DUT waveforms
    int t_x656 = -1, t_hs_fall = -1, hs_run = 0, hs_low_len = -1, von_run = 0, von_len = -1;
    int fs_first = -1, fs_period = -1, t_yvs = -1, t_vs_fall = -1, vs_run = 0, vs_low_len = -1;
    logic [9:0] prev_fx = 10'd0, prev_sy = 10'd0;
    logic prev_fhs = 1'b1, prev_fvon = 1'b0, prev_svs = 1'b1;

    function automatic obs_t model(input int kk, input int ha, input int hf, input int hs,
                                   input int hb, input int va, input int vf, input int vs,
                                   input int vb, input logic [7:0] trgb);
        obs_t o;
        int ht, tot, m, pi, p, px, py;
        logic act;
        o = '{rgb: 8'h00, hs: 1'b1, vs: 1'b1, von: 1'b0, x: 10'd0, y: 10'd0, fs: 1'b0};
        ht  = ha + hf + hs + hb;
        tot = ht * (va + vf + vs + vb);
        m   = kk / 2;
        pi  = m % tot;
        o.x = 10'(pi % ht);
        o.y = 10'(pi / ht);
        if (kk >= 2) begin
            p   = (m - 1) % tot;
            px  = p % ht;
            py  = p / ht;
            act = (px < ha) && (py < va);
            o.von = act;
            o.hs  = !((px >= ha + hf) && (px < ha + hf + hs));
            o.vs  = !((py >= va + vf) && (py < va + vf + vs));
            o.rgb = act ? trgb : 8'h00;
            o.fs  = ((kk % 2) == 0) && (p == 0);
        end
        return o;
    endfunction

    function automatic obs_t sample_full();
        return '{rgb: vif_full.rgb_out, hs: vif_full.hsync, vs: vif_full.vsync,
                 von: vif_full.video_on, x: vif_full.pixel_x, y: vif_full.pixel_y,
                 fs: vif_full.frame_start};
    endfunction

    function automatic obs_t sample_small();
        return '{rgb: vif_small.rgb_out, hs: vif_small.hsync, vs: vif_small.vsync,
                 von: vif_small.video_on, x: vif_small.pixel_x, y: vif_small.pixel_y,
                 fs: vif_small.frame_start};
    endfunction

    task automatic check_obs(input string name, input obs_t act, input obs_t exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s k=%0d: got rgb=%h hs=%b vs=%b von=%b x=%0d y=%0d fs=%b, need rgb=%h hs=%b vs=%b von=%b x=%0d y=%0d fs=%b",
                     name, k, act.rgb, act.hs, act.vs, act.von, act.x, act.y, act.fs,
                     exp.rgb, exp.hs, exp.vs, exp.von, exp.x, exp.y, exp.fs);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        vec_cnt++;
        if (act != exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0d, need %0d", name, act, exp);
        end else begin
            $display("check %s = %0d ok", name, act);
        end
    endtask

    task automatic measure(input obs_t af, input obs_t as);
        if (af.x == 10'd656 && prev_fx != 10'd656 && t_x656 < 0) t_x656 = cyc;
        if (!af.hs && prev_fhs && t_hs_fall < 0) t_hs_fall = cyc;
        if (!af.hs) hs_run++;
        else if (!prev_fhs && hs_low_len < 0) hs_low_len = hs_run;
        if (af.von) von_run++;
        else if (prev_fvon && von_len < 0) von_len = von_run;
        if (as.fs) begin
            if (fs_first < 0) fs_first = cyc;
            else if (fs_period < 0) fs_period = cyc - fs_first;
        end
        if (as.y == 10'(SVA + SVF) && prev_sy != as.y && as.x == 10'd0 && t_yvs < 0) t_yvs = cyc;
        if (!as.vs && prev_svs && t_vs_fall < 0) t_vs_fall = cyc;
        if (!as.vs) vs_run++;
        else if (!prev_svs && vs_low_len < 0) vs_low_len = vs_run;
        prev_fx = af.x; prev_fhs = af.hs; prev_fvon = af.von;
        prev_sy = as.y; prev_svs = as.vs;
    endtask

    // One CLK_IN edge: drive RGB_IN, push the expected outputs, then pop and compare.
    task automatic step(input bit meas_on);
        int kn, pf;
        obs_t af, as;
        kn = k + 1;
        if ((kn % 2) == 0) begin
            pf = (kn / 2 - 1) % F_TOT;
            vif_full.rgb_in  = (pf < F_HT) ? 8'hFF : 8'((pf % F_HT) % 256);
            vif_small.rgb_in = 8'hE3;
            trgb_full  = vif_full.rgb_in;
            trgb_small = vif_small.rgb_in;
        end else begin
            vif_full.rgb_in  = 8'($urandom);
            vif_small.rgb_in = 8'($urandom);
        end
        q_full.push_back(model(kn, FHA, FHF, FHS, FHB, FVA, FVF, FVS, FVB, trgb_full));
        q_small.push_back(model(kn, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, trgb_small));
        @(posedge clk);
        #1;
        k = kn;
        cyc++;
        af = sample_full();
        as = sample_small();
        check_obs("full_scoreboard", af, q_full.pop_front());
        check_obs("small_scoreboard", as, q_small.pop_front());
        if (meas_on) measure(af, as);
    endtask

    vec_t tab[6];
    int   fs_after;

    initial begin
        rst_obs = '{rgb: 8'h00, hs: 1'b1, vs: 1'b1, von: 1'b0, x: 10'd0, y: 10'd0, fs: 1'b0};
        tab[0] = '{1'b0, 8'h00, 8'h00, rst_obs, rst_obs};
        tab[1] = '{1'b0, 8'hFF, 8'hE3, rst_obs, rst_obs};
        tab[2] = '{1'b0, 8'h5A, 8'hA5, rst_obs, rst_obs};
        tab[3] = '{1'b0, 8'h81, 8'h18, rst_obs, rst_obs};
        tab[4] = '{1'b1, 8'h3C, 8'hC3, rst_obs, rst_obs};
        tab[5] = '{1'b1, 8'hFF, 8'hE3,
                   '{rgb: 8'hFF, hs: 1'b1, vs: 1'b1, von: 1'b1, x: 10'd1, y: 10'd0, fs: 1'b1},
                   '{rgb: 8'hE3, hs: 1'b1, vs: 1'b1, von: 1'b1, x: 10'd1, y: 10'd0, fs: 1'b1}};

        vif_full.rgb_in  = 8'h00;
        vif_small.rgb_in = 8'h00;
        k = 0;
        for (int i = 0; i < 6; i++) begin
            rst_n            = tab[i].rst_n;
            vif_full.rgb_in  = tab[i].rgb_full;
            vif_small.rgb_in = tab[i].rgb_small;
            @(posedge clk);
            #1;
            check_obs($sformatf("table%0d_full", i), sample_full(), tab[i].exp_full);
            check_obs($sformatf("table%0d_small", i), sample_small(), tab[i].exp_small);
        end

        // table left both DUTs two edges past release with (0,0) loaded
        k = 2;
        cyc = 2;
        trgb_full  = 8'hFF;
        trgb_small = 8'hE3;
        measure(sample_full(), sample_small());
        for (int n = 0; n < 4000; n++) step(1'b1);

        check_int("hsync_fall_after_x656", t_hs_fall - t_x656, 2);
        check_int("hsync_low_cycles", hs_low_len, 2 * FHS);
        check_int("video_on_cycles", von_len, 2 * FHA);
        check_int("frame_start_period", fs_period, 2 * S_TOT);
        check_int("vsync_fall_after_y", t_vs_fall - t_yvs, 2);
        check_int("vsync_low_cycles", vs_low_len, 2 * SVS * S_HT);

        // run the small frame to (10,7) and pull reset between edges
        for (int n = 0; n < 2000; n++) begin
            if ((k % 2) == 0 && ((k / 2) % S_TOT) == 7 * S_HT + 10) break;
            step(1'b0);
        end
        check_int("pre_reset_x", int'(vif_small.pixel_x), 10);
        check_int("pre_reset_y", int'(vif_small.pixel_y), 7);
        #1;
        rst_n = 1'b0;
        #1;
        check_obs("async_reset_full", sample_full(), rst_obs);
        check_obs("async_reset_small", sample_small(), rst_obs);
        @(posedge clk);
        #1;
        check_obs("held_reset_full", sample_full(), rst_obs);
        check_obs("held_reset_small", sample_small(), rst_obs);
        rst_n = 1'b1;
        k = 0;
        fs_after = -1;
        for (int n = 0; n < 700; n++) begin
            step(1'b0);
            if (vif_small.frame_start && fs_after < 0) fs_after = k;
        end
        check_int("frame_start_edge_after_reset", fs_after, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule
